// File: rtl/dac_pkg.sv
// Shared constants and helpers for the per-channel DAC processing block.
package dac_pkg;

    // Acquisition state-machine codes used by the DAC path.
    localparam logic [31:0] MS_WAIT    = 32'd99;
    localparam logic [31:0] MS_CLK1_A  = 32'd100;
    localparam logic [31:0] MS_CLK9_D  = 32'd135;
    localparam logic [31:0] MS_CLK18_C = 32'd170;
    localparam logic [31:0] MS_CLK27_B = 32'd205;

    localparam logic [15:0] MIDSCALE = 16'd32768;

    // AD5662 word: 6 don't-care zeros, 2 power-down bits, 16 data bits.
    localparam int unsigned SPI_FRAME_BITS   = 24;
    localparam int unsigned SPI_SHIFT_CYCLES = 2 * SPI_FRAME_BITS;

    typedef enum logic [0:0] {
        SpiIdle,
        SpiShift
    } spi_state_e;

    // Clamp a wide signed value into the signed 16-bit range.
    function automatic logic signed [15:0] sat16(input logic signed [33:0] x);
        if (x > 34'sd32767) begin
            return 16'sh7fff;
        end else if (x < -34'sd32768) begin
            return 16'sh8000;
        end else begin
            return x[15:0];
        end
    endfunction

endpackage

// File: rtl/dac_modified_spi.sv
// AD5662-style 24-bit serializer. SCLK runs at half the system clock, DIN is
// updated as SCLK rises so the DAC can sample it on the falling edge.
module dac_spi_tx
    import dac_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [15:0] i_data,
    output logic        o_busy,
    output logic        o_sync,
    output logic        o_sclk,
    output logic        o_din
);

    localparam logic [5:0] LastCnt = 6'(SPI_SHIFT_CYCLES - 1);

    spi_state_e                r_state;
    logic [5:0]                r_cnt;
    logic [SPI_FRAME_BITS-1:0] r_shift;
    logic                      r_sync;
    logic                      r_sclk;
    logic                      r_din;
    logic [SPI_FRAME_BITS-1:0] w_frame;

    assign w_frame = {8'h00, i_data};

    // Frame sequencer: load on start, then 48 half-periods of SCLK, then release SYNC.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= SpiIdle;
            r_cnt   <= '0;
            r_shift <= '0;
            r_sync  <= 1'b1;
            r_sclk  <= 1'b0;
            r_din   <= 1'b0;
        end else begin
            case (r_state)
                SpiIdle: begin
                    if (i_start) begin
                        r_state <= SpiShift;
                        r_cnt   <= '0;
                        r_sync  <= 1'b0;
                        r_sclk  <= 1'b1;
                        r_din   <= w_frame[SPI_FRAME_BITS-1];
                        r_shift <= {w_frame[SPI_FRAME_BITS-2:0], 1'b0};
                    end
                end
                SpiShift: begin
                    if (r_cnt == LastCnt) begin
                        r_state <= SpiIdle;
                        r_sync  <= 1'b1;
                        r_sclk  <= 1'b0;
                        r_din   <= 1'b0;
                    end else begin
                        r_cnt  <= r_cnt + 6'd1;
                        r_sclk <= ~r_sclk;
                        // Present the next bit only as SCLK goes high.
                        if (!r_sclk) begin
                            r_din   <= r_shift[SPI_FRAME_BITS-1];
                            r_shift <= {r_shift[SPI_FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
                default: r_state <= SpiIdle;
            endcase
        end
    end

    assign o_busy = (r_state == SpiShift);
    assign o_sync = r_sync;
    assign o_sclk = r_sclk;
    assign o_din  = r_din;

endmodule

// File: rtl/dac_modified.sv
// Per-channel DAC conditioning: reference subtraction, first-order HPF, gain,
// noise blanking, threshold/window detection and SPI output.
module dac_modified
    import dac_pkg::*;
(
    input  logic        dataclk,
    input  logic        reset,
    input  logic [31:0] main_state,
    input  logic [5:0]  channel,
    input  logic [15:0] DAC_input,
    input  logic [15:0] DAC_sequencer_in,
    input  logic        use_sequencer,
    input  logic        DAC_en,
    input  logic [2:0]  gain,
    input  logic [6:0]  noise_suppress,
    input  logic [15:0] DAC_thrsh,
    input  logic        DAC_thrsh_pol,
    input  logic [15:0] DAC_fsm_start_win_in,
    input  logic [15:0] DAC_fsm_stop_win_in,
    input  logic [15:0] DAC_fsm_state_counter_in,
    input  logic [15:0] HPF_coefficient,
    input  logic        HPF_en,
    input  logic        software_reference_mode,
    input  logic [15:0] software_reference,
    output logic        DAC_SYNC,
    output logic        DAC_SCLK,
    output logic        DAC_DIN,
    output logic        DAC_thrsh_out,
    output logic        DAC_fsm_inwin_out,
    output logic [15:0] DAC_register
);

    logic signed [31:0] r_lp;   // Q16.16 low-pass estimate
    logic signed [15:0] r_y;
    logic [15:0]        r_dac;
    logic               r_thrsh;
    logic               r_inwin;

    logic               w_stage_a;
    logic               w_stage_b;
    logic signed [17:0] w_in_s;
    logic signed [17:0] w_ref_s;
    logic signed [17:0] w_s_raw;
    logic signed [15:0] w_s;
    logic signed [16:0] w_h;
    logic signed [33:0] w_prod;
    logic signed [31:0] w_lp_next;
    logic signed [15:0] w_y_next;
    logic signed [23:0] w_shift;
    logic signed [15:0] w_g;
    logic [16:0]        w_g17;
    logic [16:0]        w_mag;
    logic [15:0]        w_gb;
    logic [15:0]        w_v;
    logic               w_thrsh;
    logic               w_inwin;
    logic               w_spi_busy;

    assign w_stage_a = (main_state == MS_CLK9_D) && (channel == 6'd0);
    assign w_stage_b = (main_state == MS_CLK18_C) && (channel == 6'd0);

    // Stage A datapath: offset-binary to signed, optional reference, HPF.
    assign w_in_s    = $signed({2'b00, DAC_input}) - 18'sd32768;
    assign w_ref_s   = $signed({2'b00, software_reference}) - 18'sd32768;
    assign w_s_raw   = software_reference_mode ? (w_in_s - w_ref_s) : w_in_s;
    assign w_s       = sat16({{16{w_s_raw[17]}}, w_s_raw});
    assign w_h       = $signed({w_s[15], w_s}) - $signed({r_lp[31], r_lp[31:16]});
    assign w_prod    = $signed({1'b0, HPF_coefficient}) * w_h;
    assign w_lp_next = 32'(34'(r_lp) + w_prod);
    assign w_y_next  = HPF_en ? sat16({{17{w_h[16]}}, w_h}) : w_s;

    // Stage B datapath: gain, blanking, back to offset binary.
    assign w_shift = $signed({{8{r_y[15]}}, r_y}) <<< gain;
    assign w_g     = sat16({{10{w_shift[23]}}, w_shift});
    assign w_g17   = {w_g[15], w_g};
    assign w_mag   = w_g[15] ? (17'd0 - w_g17) : w_g17;
    assign w_gb    = (w_mag < {6'd0, noise_suppress, 4'd0}) ? 16'd0 : w_g;

    // Output value selection with sequencer and enable overrides.
    always_comb begin
        w_v = {~w_gb[15], w_gb[14:0]};
        if (use_sequencer) begin
            w_v = DAC_sequencer_in;
        end
        if (!DAC_en) begin
            w_v = MIDSCALE;
        end
    end

    assign w_thrsh = DAC_thrsh_pol ? (w_v >= DAC_thrsh) : (w_v <= DAC_thrsh);
    assign w_inwin = w_thrsh
                     && (DAC_fsm_start_win_in <= DAC_fsm_state_counter_in)
                     && (DAC_fsm_state_counter_in <= DAC_fsm_stop_win_in);

    // Stage A registers: filter state updates every frame regardless of HPF_en.
    always_ff @(posedge dataclk) begin
        if (!reset) begin
            r_lp <= '0;
            r_y  <= '0;
        end else if (w_stage_a) begin
            r_lp <= w_lp_next;
            r_y  <= w_y_next;
        end
    end

    // Stage B registers: commit the processed value and detection flags.
    always_ff @(posedge dataclk) begin
        if (!reset) begin
            r_dac   <= MIDSCALE;
            r_thrsh <= 1'b0;
            r_inwin <= 1'b0;
        end else if (w_stage_b) begin
            r_dac   <= w_v;
            r_thrsh <= w_thrsh;
            r_inwin <= w_inwin;
        end
    end

    dac_spi_tx u_spi (
        .i_clk   (dataclk),
        .i_rst_n (reset),
        .i_start (w_stage_b && DAC_en && !w_spi_busy),
        .i_data  (w_v),
        .o_busy  (w_spi_busy),
        .o_sync  (DAC_SYNC),
        .o_sclk  (DAC_SCLK),
        .o_din   (DAC_DIN)
    );

    assign DAC_register      = r_dac;
    assign DAC_thrsh_out     = r_thrsh;
    assign DAC_fsm_inwin_out = r_inwin;

endmodule

// File: tb/tb_dac_modified.sv
// Scoreboard bench for dac_modified: a behavioural model predicts each committed
// value and SPI word; monitors compare them when the DUT presents them.
module tb_dac_modified;
    import dac_pkg::*;

    logic        dataclk = 1'b0;
    logic        reset;
    logic [31:0] main_state;
    logic [5:0]  channel;
    logic [15:0] DAC_input, DAC_sequencer_in, DAC_thrsh;
    logic [15:0] DAC_fsm_start_win_in, DAC_fsm_stop_win_in, DAC_fsm_state_counter_in;
    logic [15:0] HPF_coefficient, software_reference;
    logic        use_sequencer, DAC_en, DAC_thrsh_pol, HPF_en, software_reference_mode;
    logic [2:0]  gain;
    logic [6:0]  noise_suppress;
    logic        DAC_SYNC, DAC_SCLK, DAC_DIN, DAC_thrsh_out, DAC_fsm_inwin_out;
    logic [15:0] DAC_register;

    always #5 dataclk = ~dataclk;

    dac_modified dut (
        .dataclk                  (dataclk),
        .reset                    (reset),
        .main_state               (main_state),
        .channel                  (channel),
        .DAC_input                (DAC_input),
        .DAC_sequencer_in         (DAC_sequencer_in),
        .use_sequencer            (use_sequencer),
        .DAC_en                   (DAC_en),
        .gain                     (gain),
        .noise_suppress           (noise_suppress),
        .DAC_thrsh                (DAC_thrsh),
        .DAC_thrsh_pol            (DAC_thrsh_pol),
        .DAC_fsm_start_win_in     (DAC_fsm_start_win_in),
        .DAC_fsm_stop_win_in      (DAC_fsm_stop_win_in),
        .DAC_fsm_state_counter_in (DAC_fsm_state_counter_in),
        .HPF_coefficient          (HPF_coefficient),
        .HPF_en                   (HPF_en),
        .software_reference_mode  (software_reference_mode),
        .software_reference       (software_reference),
        .DAC_SYNC                 (DAC_SYNC),
        .DAC_SCLK                 (DAC_SCLK),
        .DAC_DIN                  (DAC_DIN),
        .DAC_thrsh_out            (DAC_thrsh_out),
        .DAC_fsm_inwin_out        (DAC_fsm_inwin_out),
        .DAC_register             (DAC_register)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int v;
        int thr;
        int inwin;
    } exp_t;

    exp_t   exp_q[$];
    int     spi_q[$];
    bit     abort_pending = 1'b0;
    longint m_lp;
    int     m_y;
    int     m_reg;

    function automatic int clamp16(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return int'(x);
    endfunction

    task automatic model_reset();
        m_lp  = 0;
        m_y   = 0;
        m_reg = 32768;
    endtask

    // One channel-0 frame: stage A then stage B, inputs held for the frame.
    task automatic model_frame();
        int     s, h, g, v, thr, inwin;
        longint hi;
        exp_t   e;
        s = int'(DAC_input) - 32768;
        if (software_reference_mode) s = s - (int'(software_reference) - 32768);
        s    = clamp16(s);
        hi   = m_lp >>> 16;
        h    = s - int'(hi);
        m_lp = m_lp + longint'(HPF_coefficient) * longint'(h);
        m_y  = HPF_en ? clamp16(h) : s;
        g = clamp16(longint'(m_y) * (longint'(1) << gain));
        if (((g < 0) ? -g : g) < int'(noise_suppress) * 16) g = 0;
        v = g + 32768;
        if (use_sequencer) v = int'(DAC_sequencer_in);
        if (!DAC_en) v = 32768;
        thr   = DAC_thrsh_pol ? int'(v >= int'(DAC_thrsh)) : int'(v <= int'(DAC_thrsh));
        inwin = int'(thr == 1 && DAC_fsm_start_win_in <= DAC_fsm_state_counter_in
                     && DAC_fsm_state_counter_in <= DAC_fsm_stop_win_in);
        m_reg   = v;
        e.v     = v;
        e.thr   = thr;
        e.inwin = inwin;
        exp_q.push_back(e);
        if (DAC_en) spi_q.push_back(v);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic frame_commit(input int ch);
        @(negedge dataclk);
        main_state = MS_CLK9_D;
        channel    = 6'(ch);
        @(negedge dataclk);
        main_state = 32'd140;
        @(negedge dataclk);
        main_state = MS_CLK18_C;
        if (ch == 0) model_frame();
        @(negedge dataclk);
        main_state = MS_WAIT;
    endtask

    task automatic run_frame(input int ch);
        frame_commit(ch);
        repeat (52) @(negedge dataclk);
    endtask

    task automatic do_reset();
        @(negedge dataclk);
        reset = 1'b0;
        repeat (3) @(negedge dataclk);
        reset = 1'b1;
        model_reset();
    endtask

    // ---------------- register monitor ----------------
    initial begin : reg_mon
        exp_t e;
        forever begin
            @(posedge dataclk);
            if (reset && main_state == MS_CLK18_C && channel == 6'd0) begin
                #1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL reg_unexpected: commit with no prediction, got %0d",
                             DAC_register);
                end else begin
                    e = exp_q.pop_front();
                    check("dac_register", longint'(DAC_register), longint'(e.v));
                    check("thrsh_out", longint'(DAC_thrsh_out), longint'(e.thr));
                    check("inwin_out", longint'(DAC_fsm_inwin_out), longint'(e.inwin));
                end
            end
        end
    end

    // ---------------- SPI monitor ----------------
    initial begin : spi_mon
        bit          cap;
        int          low, nfall, ev;
        logic [23:0] word;
        logic        p_sync, p_sclk, p_din;
        cap = 1'b0; low = 0; nfall = 0; word = '0;
        p_sync = 1'b1; p_sclk = 1'b0; p_din = 1'b0;
        forever begin
            @(posedge dataclk);
            #1;
            if (!cap && p_sync && !DAC_SYNC) begin
                cap = 1'b1; low = 0; nfall = 0; word = '0;
            end
            if (cap && !DAC_SYNC) begin
                low++;
                if (p_sclk && !DAC_SCLK) begin
                    word = {word[22:0], p_din};
                    nfall++;
                end
            end else if (cap && DAC_SYNC) begin
                cap = 1'b0;
                if (abort_pending) begin
                    abort_pending = 1'b0;
                    if (spi_q.size() > 0) ev = spi_q.pop_front();
                end else if (spi_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spi_unexpected: frame word %06h with none expected", word);
                end else begin
                    ev = spi_q.pop_front();
                    check("spi_word", longint'(word), longint'(ev));
                    check("spi_sync_low_cycles", longint'(low), 48);
                    check("spi_sclk_falls", longint'(nfall), 24);
                end
            end
            p_sync = DAC_SYNC;
            p_sclk = DAC_SCLK;
            p_din  = DAC_DIN;
        end
    end

    // ---------------- main sequence ----------------
    initial begin : main_seq
        reset = 1'b0; main_state = MS_WAIT; channel = 6'd0;
        DAC_input = 16'd32768; DAC_sequencer_in = 16'd0; use_sequencer = 1'b0;
        DAC_en = 1'b1; gain = 3'd0; noise_suppress = 7'd0;
        DAC_thrsh = 16'd0; DAC_thrsh_pol = 1'b0;
        DAC_fsm_start_win_in = 16'd0; DAC_fsm_stop_win_in = 16'd0;
        DAC_fsm_state_counter_in = 16'd0;
        HPF_coefficient = 16'd0; HPF_en = 1'b0;
        software_reference_mode = 1'b0; software_reference = 16'd32768;
        model_reset();

        repeat (3) @(negedge dataclk);
        check("reset_dac_register", longint'(DAC_register), 32768);
        check("reset_sync", longint'(DAC_SYNC), 1);
        check("reset_sclk", longint'(DAC_SCLK), 0);
        check("reset_din", longint'(DAC_DIN), 0);
        check("reset_thrsh", longint'(DAC_thrsh_out), 0);
        check("reset_inwin", longint'(DAC_fsm_inwin_out), 0);
        reset = 1'b1;

        // Plain pass-through.
        DAC_input = 16'd33768;
        run_frame(0);

        // High-pass step response from a clean filter state.
        do_reset();
        HPF_en = 1'b1; HPF_coefficient = 16'd3343; DAC_input = 16'd40000;
        for (int i = 0; i < 500; i++) run_frame(0);
        check("hpf_settled_within_2", longint'(DAC_register >= 16'd32766
                                               && DAC_register <= 16'd32770), 1);

        // Gain saturation and noise blanking.
        HPF_en = 1'b0; gain = 3'd3; DAC_input = 16'(32768 + 5000);
        run_frame(0);
        gain = 3'd7; DAC_input = 16'(32768 - 300);
        run_frame(0);
        gain = 3'd0; noise_suppress = 7'd4; DAC_input = 16'(32768 + 50);
        run_frame(0);
        noise_suppress = 7'd0;

        // Threshold and window.
        DAC_thrsh = 16'd30000; DAC_thrsh_pol = 1'b0;
        DAC_fsm_start_win_in = 16'd5; DAC_fsm_stop_win_in = 16'd10;
        DAC_input = 16'd29000; DAC_fsm_state_counter_in = 16'd7;
        run_frame(0);
        DAC_fsm_state_counter_in = 16'd11;
        run_frame(0);
        DAC_input = 16'd31000; DAC_fsm_state_counter_in = 16'd7;
        run_frame(0);
        DAC_input = 16'd29000; DAC_fsm_start_win_in = 16'd10; DAC_fsm_stop_win_in = 16'd5;
        run_frame(0);
        DAC_thrsh_pol = 1'b1; DAC_input = 16'd31000;
        run_frame(0);

        // Sequencer bypass and disable.
        use_sequencer = 1'b1; DAC_sequencer_in = 16'hABCD;
        run_frame(0);
        use_sequencer = 1'b0; DAC_en = 1'b0;
        run_frame(0);
        DAC_en = 1'b1;

        // Software reference cancels an equal input.
        software_reference_mode = 1'b1; software_reference = 16'd33000; DAC_input = 16'd33000;
        run_frame(0);
        software_reference_mode = 1'b0;

        // Another channel must leave everything untouched.
        DAC_input = 16'd1234;
        run_frame(3);
        check("hold_other_channel", longint'(DAC_register), longint'(m_reg));

        // Randomised frames.
        for (int i = 0; i < 60; i++) begin
            DAC_input                = 16'($urandom);
            DAC_sequencer_in         = 16'($urandom);
            use_sequencer            = ($urandom_range(0, 3) == 0);
            DAC_en                   = ($urandom_range(0, 7) != 0);
            gain                     = 3'($urandom_range(0, 7));
            noise_suppress           = 7'($urandom_range(0, 15));
            DAC_thrsh                = 16'($urandom);
            DAC_thrsh_pol            = 1'($urandom_range(0, 1));
            DAC_fsm_start_win_in     = 16'($urandom_range(0, 20));
            DAC_fsm_stop_win_in      = 16'($urandom_range(0, 20));
            DAC_fsm_state_counter_in = 16'($urandom_range(0, 20));
            HPF_coefficient          = 16'($urandom);
            HPF_en                   = 1'($urandom_range(0, 1));
            software_reference_mode  = 1'($urandom_range(0, 1));
            software_reference       = 16'($urandom);
            run_frame(0);
        end

        // Reset in the middle of an SPI frame.
        DAC_en = 1'b1; use_sequencer = 1'b1; DAC_sequencer_in = 16'h5A5A;
        frame_commit(0);
        repeat (10) @(negedge dataclk);
        abort_pending = 1'b1;
        reset = 1'b0;
        @(posedge dataclk);
        #1;
        check("abort_sync_high", longint'(DAC_SYNC), 1);
        check("abort_sclk_low", longint'(DAC_SCLK), 0);
        check("abort_dac_register", longint'(DAC_register), 32768);
        @(negedge dataclk);
        reset = 1'b1;
        model_reset();
        use_sequencer = 1'b0; DAC_input = 16'd20000; HPF_en = 1'b0;
        software_reference_mode = 1'b0; gain = 3'd0; noise_suppress = 7'd0;
        run_frame(0);

        repeat (60) @(negedge dataclk);
        check("scoreboard_drained", longint'(exp_q.size()), 0);
        check("spi_queue_drained", longint'(spi_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_modified.md
# dac_modified

Per-channel analog-output (DAC) processing block for the acquisition board. It takes one 16-bit offset-binary amplifier sample per frame and conditions it: optional software-reference subtraction, first-order high-pass filter, gain, noise blanking, and threshold/window detection. The result is exposed on `DAC_register` and serialized to an AD5662-style 16-bit SPI DAC. It sits downstream of the main acquisition state machine, which supplies `main_state` and `channel`.

## Interface
- No parameters. State codes are package constants: MS_WAIT=99, MS_CLK1_A=100, MS_CLK9_D=135, MS_CLK18_C=170, MS_CLK27_B=205.
- dataclk  in  1  system clock; all logic rises on it
- reset  in  1  synchronous, active-low reset
- main_state  in  32  acquisition state-machine code
- channel  in  6  current SPI channel slot (0–19)
- DAC_input  in  16  amplifier sample, offset binary (32768 = 0)
- DAC_sequencer_in  in  16  direct DAC value for the sequencer path
- use_sequencer  in  1  1: output DAC_sequencer_in and bypass all processing
- DAC_en  in  1  0: output forced to midscale and no SPI frames
- gain  in  3  left shift 0–7, saturating
- noise_suppress  in  7  blanking half-band, in units of 16 LSB
- DAC_thrsh  in  16  threshold, offset binary
- DAC_thrsh_pol  in  1  0: trigger when value <= thrsh; 1: trigger when value >= thrsh
- DAC_fsm_start_win_in, DAC_fsm_stop_win_in  in  16  inclusive window bounds
- DAC_fsm_state_counter_in  in  16  external window counter
- HPF_coefficient  in  16  unsigned, alpha = coef/65536 (3343 ≈ 250 Hz at 30 kS/s)
- HPF_en  in  1  select high-passed path
- software_reference_mode  in  1  subtract software_reference
- software_reference  in  16  offset-binary reference sample
- DAC_SYNC  out  1  SPI frame sync, active low
- DAC_SCLK  out  1  SPI clock
- DAC_DIN  out  1  SPI data, MSB first
- DAC_thrsh_out  out  1  registered threshold flag
- DAC_fsm_inwin_out  out  1  threshold AND counter in window
- DAC_register  out  16  processed offset-binary DAC value

## Operation
All processing stages act only when channel == 0. In other states or channels, the registers hold their values.

- **Stage A, at main_state == 135:**
  - s = DAC_input − 32768, as signed 17-bit.
  - If software_reference_mode is set, s −= (software_reference − 32768). Saturate s to [−32768, 32767].
  - HPF: lp is a signed 32-bit register, Q16.16. h = s − lp[31:16].
  - lp += HPF_coefficient × h, using a signed 34-bit product. The update happens every frame, regardless of HPF_en.
  - Register y = HPF_en ? sat16(h) : s.
- **Stage B, at main_state == 170:**
  - g = sat16(y <<< gain).
  - If |g| < noise_suppress × 16, then g = 0.
  - v = g + 32768.
  - If use_sequencer is set, v = DAC_sequencer_in.
  - If DAC_en is 0, v = 32768.
  - Register DAC_register ← v.
  - DAC_thrsh_out ← pol ? (v ≥ DAC_thrsh) : (v ≤ DAC_thrsh).
  - DAC_fsm_inwin_out ← (new thrsh flag) && start ≤ counter ≤ stop.
- **SPI serializer:**
  - Starts at the edge where stage B commits, provided DAC_en = 1.
  - Frame is 24 bits: 6 zeros, 2 power-down bits "00", then v[15:0] MSB first.
  - States: IDLE → SHIFT (48 cycles) → IDLE.
  - A start request while in SHIFT is ignored; the word already in flight completes.

## Timing
- Reset values: DAC_register = 32768; lp = 0; y = 0; DAC_SYNC = 1; DAC_SCLK = 0; DAC_DIN = 0; DAC_thrsh_out = 0; DAC_fsm_inwin_out = 0; serializer in IDLE.
- A reset asserted mid-frame aborts the frame immediately and DAC_SYNC returns high.
- Latency: a DAC_input held at the 135 edge appears on DAC_register after the 170 edge (35 state codes later). A reader sampling at the 170 edge sees the previous frame's value.
- SPI:
  - DAC_SYNC falls on the cycle after the commit and stays low for 48 cycles.
  - SCLK toggles every dataclk, so SCLK = dataclk/2.
  - DIN changes while SCLK is high; the DAC samples on the SCLK falling edge.
  - DAC_SYNC rises after the 24th falling edge.
- Boundaries:
  - Arithmetic saturates; it never wraps.
  - gain = 7 with any |y| > 255 clips to ±full scale.
  - If start > stop, inwin is always 0.

## Structure
- Shared package `dac_pkg`: main_state codes, MIDSCALE = 16'd32768, SPI frame length of 24, and the sat16 function.
- Natural sub-module: `dac_spi_tx`, the 24-bit AD5662 serializer with a start/busy interface.
- The filter, gain and threshold logic stays in the top module.

## Test plan
- Reset low for 3 cycles → DAC_register = 32768 and DAC_SYNC = 1. HPF_en = 0, gain = 0, input 33768 → DAC_register = 33768 after the next 170 edge.
- HPF_en = 1, coef = 3343, constant input 40000 → the first output is 40000, then it decays monotonically toward 32768 within ±2 LSB after 500 frames.
- HPF_en = 0, gain = 3, input 32768+5000 → output 65535 (saturated). noise_suppress = 4, input 32768+50 → 32768.
- pol = 0, thrsh = 30000: input 29000 → thrsh_out = 1; input 31000 → thrsh_out = 0. With start = 5, stop = 10: counter 7 → inwin = 1; counter 11 → inwin = 0.
- use_sequencer = 1, seq = 0xABCD → DAC_register = 0xABCD, and the SPI shows 0x00ABCD over 24 SCLK falls. DAC_en = 0 → 32768 and no SYNC low.
- software_reference_mode = 1, ref = 33000, input 33000 → output 32768. Reset asserted mid-SPI → SYNC high on the next cycle.
